enc83_serializer: RTL and testbench

- Inverse of the 3-to-8 one-hot decoder used for ALU operation select: takes an 8-bit request/one-hot vector and emits the 3-bit index of each set bit, one index per handshake.
- Sits between a status/flag vector producer and any consumer of 3-bit selects, for example decoder `sel` inputs or opcode queues.
- Single vector buffer; valid/ready on both sides.

---
 rtl/enc83_serializer_if.sv | 23 ++
 rtl/enc83_serializer.sv | 86 ++++++++
 tb/tb_enc83_serializer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/enc83_serializer_if.sv
// rtl/enc83_serializer_if.sv - vector-in / index-out handshake bundle for enc83_serializer
interface enc83_serializer_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/enc83_serializer.sv
// rtl/enc83_serializer.sv - one-hot/request vector to index serializer; ENC83_MSB_FIRST_EN selects highest-bit-first order
module enc83_serializer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  enc83_serializer_if.slave bus,
  output logic              zero_flag,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] sel_idx;
  logic             one_left;

  // The last match in the scan wins, so scan direction sets emission order.
  always_comb begin
    sel_idx = '0;
`ifdef ENC83_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) sel_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_W'(i);
    end
`endif
  end

  assign one_left  = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign zero_flag = zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  // Outputs come from registered state only; in_* and out_ready steer next state.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    zero_d        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_vec == '0) begin
            zero_d = 1'b1;
          end else begin
            pending_d = bus.in_vec;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_idx   = sel_idx;
        bus.out_last  = one_left;
        if (bus.out_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << sel_idx);
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enc83_serializer.sv
// tb/tb_enc83_serializer.sv - directed bench with queue-based index model for enc83_serializer
module tb_enc83_serializer;

  logic clk = 1'b0;
  logic rst;
  logic zero_flag;
  logic busy;

  always #5 clk = ~clk;

  enc83_serializer_if #(.WIDTH(8), .IDX_W(3)) bus ();

  enc83_serializer #(.WIDTH(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .zero_flag (zero_flag),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int got_log[$];
  logic zero_exp = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_vec(logic [7:0] v);
`ifdef ENC83_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
`endif
  endfunction

  function automatic void chk_log(string name, int e[$]);
    chk({name, "_count"}, got_log.size(), e.size());
    for (int i = 0; i < e.size() && i < got_log.size(); i++)
      chk({name, "_idx"}, got_log[i], e[i]);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      zero_exp = 1'b0;
    end else begin
      automatic bit idle = (exp_q.size() == 0);
      chk("out_valid", bus.out_valid, !idle);
      chk("busy", busy, !idle);
      chk("in_ready", bus.in_ready, idle);
      chk("zero_flag", zero_flag, zero_exp);
      if (bus.out_valid && !idle) begin
        chk("out_idx", bus.out_idx, exp_q[0]);
        chk("out_last", bus.out_last, exp_q.size() == 1);
        if (bus.out_ready) begin
          got_log.push_back(int'(bus.out_idx));
          void'(exp_q.pop_front());
        end
      end
      zero_exp = 1'b0;
      if (bus.in_valid && idle) begin
        if (bus.in_vec == 8'h00) zero_exp = 1'b1;
        else push_vec(bus.in_vec);
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    while (!bus.in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) chk("send_timeout", budget, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'hA5;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!bus.in_ready && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 200) chk("idle_timeout", cycles, 0);
  endtask

  initial begin
    int cyc;
    int e[$];
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    got_log.delete();
    send(8'b0010_0101);
    wait_idle(cyc);
    chk("basic_cycles", cyc, 3);
`ifdef ENC83_MSB_FIRST_EN
    e = '{5, 2, 0};
`else
    e = '{0, 2, 5};
`endif
    chk_log("basic", e);

    bus.out_ready = 1'b0;
    got_log.delete();
    send(8'b1000_1000);
    repeat (3) begin
      @(posedge clk); #1;
`ifdef ENC83_MSB_FIRST_EN
      chk("bp_hold_idx", bus.out_idx, 7);
`else
      chk("bp_hold_idx", bus.out_idx, 3);
`endif
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    wait_idle(cyc);
`ifdef ENC83_MSB_FIRST_EN
    e = '{7, 3};
`else
    e = '{3, 7};
`endif
    chk_log("bp", e);

    send(8'h00);
    chk("zero_pulse", zero_flag, 1);
    chk("zero_no_valid", bus.out_valid, 0);
    chk("zero_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("zero_pulse_end", zero_flag, 0);

    got_log.delete();
    send(8'hFF);
    bus.in_valid = 1'b1;
    bus.in_vec   = 8'h01;
    chk("full_in_ready_low", bus.in_ready, 0);
    send(8'h01);
    wait_idle(cyc);
`ifdef ENC83_MSB_FIRST_EN
    e = '{7, 6, 5, 4, 3, 2, 1, 0, 0};
`else
    e = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
`endif
    chk_log("full", e);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      logic [7:0] d;
      v = 8'd1 << i;
      got_log.delete();
      send(v);
      wait_idle(cyc);
      chk("single_count", got_log.size(), 1);
      d = (got_log.size() > 0) ? (8'd1 << got_log[0]) : 8'h00;
      chk("single_roundtrip", d, v);
    end

    bus.out_ready = 1'b0;
    send(8'hF0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_idx", bus.out_idx, 0);
    chk("arst_out_last", bus.out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    got_log.delete();
    send(8'h12);
    wait_idle(cyc);
`ifdef ENC83_MSB_FIRST_EN
    e = '{4, 1};
`else
    e = '{1, 4};
`endif
    chk_log("post_rst", e);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
